// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 raster constants, mode encodings, text geometry and
// the graphics byte-address helper used by the timing generator.
package vga_pkg;

  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_VIS  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  // One counter width covers both axes; px/py ports are this wide too.
  localparam int unsigned CNT_W = $clog2((H_TOT > V_TOT) ? H_TOT : V_TOT);

  localparam logic [1:0] MODE_TEXT = 2'd0;
  localparam logic [1:0] MODE_GFX  = 2'd1;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CHAR_H = 16;
  localparam int unsigned GX_W   = $clog2(CHAR_W);
  localparam int unsigned GY_W   = $clog2(CHAR_H);
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned GFX_W  = 17;

  // (y>>1)*320 + (x>>1) built from shifts: 320 = 256 + 64.
  function automatic logic [GFX_W-1:0] gfx_byte_addr(input logic [CNT_W-1:0] x,
                                                    input logic [CNT_W-1:0] y);
    logic [GFX_W-1:0] x2;
    logic [GFX_W-1:0] y2;
    x2 = GFX_W'(x >> 1);
    y2 = GFX_W'(y >> 1);
    return (y2 << 8) + (y2 << 6) + x2;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with enable, plus the wrap,
// sync-window and visible-region decodes of the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOT     = H_TOT,
  parameter int unsigned VIS     = H_VIS,
  parameter int unsigned SYNC_LO = H_VIS + H_FP,
  parameter int unsigned SYNC_HI = H_VIS + H_FP + H_SYNC
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap_c,
  output logic             sync_c,
  output logic             vis_c
);

  assign wrap_c = en && (cnt == CNT_W'(TOT - 1));
  assign sync_c = (cnt >= CNT_W'(SYNC_LO)) && (cnt < CNT_W'(SYNC_HI));
  assign vis_c  = cnt < CNT_W'(VIS);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster timing master: syncs, blanking, pixel/text/graphics
// coordinates, line/frame pulses and the blink frame counter.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS_P  = H_VIS,
  parameter int unsigned H_FP_P   = H_FP,
  parameter int unsigned H_SYNC_P = H_SYNC,
  parameter int unsigned H_BP_P   = H_BP,
  parameter int unsigned V_VIS_P  = V_VIS,
  parameter int unsigned V_FP_P   = V_FP,
  parameter int unsigned V_SYNC_P = V_SYNC,
  parameter int unsigned V_BP_P   = V_BP
) (
  input  logic              pclk,
  input  logic              _reset,
  input  logic [1:0]        mode,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [CNT_W-1:0]  px,
  output logic [CNT_W-1:0]  py,
  output logic [COL_W-1:0]  char_col,
  output logic [ROW_W-1:0]  char_row,
  output logic [GX_W-1:0]   glyph_x,
  output logic [GY_W-1:0]   glyph_y,
  output logic [GFX_W-1:0]  gfx_addr,
  output logic [4:0]        frame_cnt,
  output logic              line_start,
  output logic              frame_start
);

  localparam int unsigned H_TOT_P = H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int unsigned V_TOT_P = V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap_c;
  logic             h_sync_c;
  logic             h_vis_c;
  logic             v_wrap_c;
  logic             v_sync_c;
  logic             v_vis_c;
  logic             vis_c;
  logic [1:0]       mode_q;
  logic             mode_unused;

  vga_axis_counter #(
    .TOT     (H_TOT_P),
    .VIS     (H_VIS_P),
    .SYNC_LO (H_VIS_P + H_FP_P),
    .SYNC_HI (H_VIS_P + H_FP_P + H_SYNC_P)
  ) u_h_axis (
    .pclk   (pclk),
    .rst_n  (_reset),
    .en     (1'b1),
    .cnt    (h_cnt),
    .wrap_c (h_wrap_c),
    .sync_c (h_sync_c),
    .vis_c  (h_vis_c)
  );

  vga_axis_counter #(
    .TOT     (V_TOT_P),
    .VIS     (V_VIS_P),
    .SYNC_LO (V_VIS_P + V_FP_P),
    .SYNC_HI (V_VIS_P + V_FP_P + V_SYNC_P)
  ) u_v_axis (
    .pclk   (pclk),
    .rst_n  (_reset),
    .en     (h_wrap_c),
    .cnt    (v_cnt),
    .wrap_c (v_wrap_c),
    .sync_c (v_sync_c),
    .vis_c  (v_vis_c)
  );

  assign vis_c = h_vis_c && v_vis_c;

  // Latched mode has no consumer inside this block yet; the pixel stage owns it.
  assign mode_unused = ^mode_q;

  // Pulses come from the wrap so they land in the cycle the counters read 0;
  // the very first frame after reset therefore carries no frame_start.
  always_ff @(posedge pclk or negedge _reset) begin
    if (!_reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank       <= 1'b1;
      px          <= '0;
      py          <= '0;
      gfx_addr    <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_q      <= MODE_TEXT;
    end else begin
      hsync       <= ~h_sync_c;
      vsync       <= ~v_sync_c;
      blank       <= ~vis_c;
      line_start  <= h_wrap_c;
      frame_start <= v_wrap_c;
      if (vis_c) begin
        px       <= h_cnt;
        py       <= v_cnt;
        gfx_addr <= gfx_byte_addr(h_cnt, v_cnt);
      end
      if (v_wrap_c) begin
        frame_cnt <= frame_cnt + 5'd1;
        mode_q    <= (mode == MODE_GFX) ? MODE_GFX : MODE_TEXT;
      end
    end
  end

  assign char_col = px[GX_W+COL_W-1:GX_W];
  assign glyph_x  = px[GX_W-1:0];
  assign char_row = py[GY_W+ROW_W-1:GY_W];
  assign glyph_y  = py[GY_W-1:0];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size, short-line and tiny-frame instances checked
// every cycle against an arithmetic raster model plus hand-computed points.
module tb_vga_timing;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [6:0]  char_col;
    logic [4:0]  char_row;
    logic [2:0]  glyph_x;
    logic [3:0]  glyph_y;
    logic [16:0] gfx_addr;
    logic [4:0]  frame_cnt;
    logic        line_start;
    logic        frame_start;
  } vout_t;

  typedef struct packed {
    int unsigned hv, hf, hs, hb, vv, vf, vs, vb;
  } geo_t;

  localparam geo_t GA = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33};
  localparam geo_t GB = '{hv:16,  hf:2,  hs:3,  hb:3,  vv:480, vf:10, vs:2, vb:33};
  localparam geo_t GC = '{hv:16,  hf:2,  hs:3,  hb:3,  vv:8,   vf:1,  vs:1, vb:2};

  logic pclk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd1, mode_c = 2'd0;
  vout_t oa, ob, oc;

  int unsigned ka, kb, kc;
  int n_run = 0;
  int n_fail = 0;

  int unsigned a_hs_first = 0, a_hs_cnt = 0, a_bl_cnt = 0, a_ls_n = 0;
  int unsigned a_ls_k [2];
  int unsigned b_vs_first = 0, b_vs_cnt = 0, b_bl_cnt = 0, b_fs_first = 0, b_fs_cnt = 0;

  always #5 pclk = ~pclk;

  vga_timing #(.H_VIS_P(GA.hv), .H_FP_P(GA.hf), .H_SYNC_P(GA.hs), .H_BP_P(GA.hb),
               .V_VIS_P(GA.vv), .V_FP_P(GA.vf), .V_SYNC_P(GA.vs), .V_BP_P(GA.vb)) dut_a (
    .pclk(pclk), ._reset(rst_a), .mode(mode_a), .hsync(oa.hsync), .vsync(oa.vsync),
    .blank(oa.blank), .px(oa.px), .py(oa.py), .char_col(oa.char_col), .char_row(oa.char_row),
    .glyph_x(oa.glyph_x), .glyph_y(oa.glyph_y), .gfx_addr(oa.gfx_addr),
    .frame_cnt(oa.frame_cnt), .line_start(oa.line_start), .frame_start(oa.frame_start));

  vga_timing #(.H_VIS_P(GB.hv), .H_FP_P(GB.hf), .H_SYNC_P(GB.hs), .H_BP_P(GB.hb),
               .V_VIS_P(GB.vv), .V_FP_P(GB.vf), .V_SYNC_P(GB.vs), .V_BP_P(GB.vb)) dut_b (
    .pclk(pclk), ._reset(rst_b), .mode(mode_b), .hsync(ob.hsync), .vsync(ob.vsync),
    .blank(ob.blank), .px(ob.px), .py(ob.py), .char_col(ob.char_col), .char_row(ob.char_row),
    .glyph_x(ob.glyph_x), .glyph_y(ob.glyph_y), .gfx_addr(ob.gfx_addr),
    .frame_cnt(ob.frame_cnt), .line_start(ob.line_start), .frame_start(ob.frame_start));

  vga_timing #(.H_VIS_P(GC.hv), .H_FP_P(GC.hf), .H_SYNC_P(GC.hs), .H_BP_P(GC.hb),
               .V_VIS_P(GC.vv), .V_FP_P(GC.vf), .V_SYNC_P(GC.vs), .V_BP_P(GC.vb)) dut_c (
    .pclk(pclk), ._reset(rst_c), .mode(mode_c), .hsync(oc.hsync), .vsync(oc.vsync),
    .blank(oc.blank), .px(oc.px), .py(oc.py), .char_col(oc.char_col), .char_row(oc.char_row),
    .glyph_x(oc.glyph_x), .glyph_y(oc.glyph_y), .gfx_addr(oc.gfx_addr),
    .frame_cnt(oc.frame_cnt), .line_start(oc.line_start), .frame_start(oc.frame_start));

  // Edges seen since each instance last left reset.
  always @(posedge pclk) begin
    ka <= rst_a ? ka + 1 : 0;
    kb <= rst_b ? kb + 1 : 0;
    kc <= rst_c ? kc + 1 : 0;
  end

  // Expected outputs after edge k: they describe raster position k-1.
  function automatic vout_t model(input geo_t g, input int unsigned k, input logic rn);
    vout_t o;
    int unsigned ht, vt, ft, q, hq, vq, lx, ly;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    ft = ht * vt;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    o.blank = 1'b1;
    if (!rn || k == 0) return o;
    q  = (k - 1) % ft;
    hq = q % ht;
    vq = q / ht;
    o.hsync = !(hq >= g.hv + g.hf && hq < g.hv + g.hf + g.hs);
    o.vsync = !(vq >= g.vv + g.vf && vq < g.vv + g.vf + g.vs);
    o.blank = !(hq < g.hv && vq < g.vv);
    if (vq >= g.vv) begin
      lx = g.hv - 1; ly = g.vv - 1;
    end else if (hq >= g.hv) begin
      lx = g.hv - 1; ly = vq;
    end else begin
      lx = hq; ly = vq;
    end
    o.px          = 10'(lx);
    o.py          = 10'(ly);
    o.char_col    = 7'(lx / 8);
    o.glyph_x     = 3'(lx % 8);
    o.char_row    = 5'(ly / 16);
    o.glyph_y     = 4'(ly % 16);
    o.gfx_addr    = 17'((ly / 2) * 320 + lx / 2);
    o.frame_cnt   = 5'((k / ft) % 32);
    o.line_start  = (k % ht) == 0;
    o.frame_start = (k % ft) == 0;
    return o;
  endfunction

  task automatic chk_out(input string nm, input int unsigned k, input vout_t got, input vout_t exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got hs=%0b vs=%0b bl=%0b px=%0d py=%0d col=%0d row=%0d gx=%0d gy=%0d ga=%0d fc=%0d ls=%0b fs=%0b | want hs=%0b vs=%0b bl=%0b px=%0d py=%0d col=%0d row=%0d gx=%0d gy=%0d ga=%0d fc=%0d ls=%0b fs=%0b",
               nm, k, got.hsync, got.vsync, got.blank, got.px, got.py, got.char_col, got.char_row,
               got.glyph_x, got.glyph_y, got.gfx_addr, got.frame_cnt, got.line_start, got.frame_start,
               exp.hsync, exp.vsync, exp.blank, exp.px, exp.py, exp.char_col, exp.char_row,
               exp.glyph_x, exp.glyph_y, exp.gfx_addr, exp.frame_cnt, exp.line_start, exp.frame_start);
    end
  endtask

  task automatic check(input string nm, input int unsigned got, input int unsigned exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic wait_ka(input int unsigned t);
    while (ka < t) begin @(posedge pclk); #1; end
  endtask

  task automatic wait_kb(input int unsigned t);
    while (kb < t) begin @(posedge pclk); #1; end
  endtask

  // Per-cycle comparison against the model, plus run statistics for the literals.
  always begin
    @(posedge pclk); #1;
    chk_out("cyc_a", ka, oa, model(GA, ka, rst_a));
    chk_out("cyc_b", kb, ob, model(GB, kb, rst_b));
    chk_out("cyc_c", kc, oc, model(GC, kc, rst_c));
    if (rst_a && ka >= 1 && ka <= 800) begin
      if (!oa.hsync) begin
        a_hs_cnt++;
        if (a_hs_first == 0) a_hs_first = ka;
      end
      if (oa.blank) a_bl_cnt++;
    end
    if (rst_a && oa.line_start && a_ls_n < 2) begin
      a_ls_k[a_ls_n] = ka;
      a_ls_n++;
    end
    if (rst_b && kb >= 1 && kb <= 12600) begin
      if (!ob.vsync) begin
        b_vs_cnt++;
        if (b_vs_first == 0) b_vs_first = kb;
      end
      if (ob.blank) b_bl_cnt++;
    end
    if (rst_b && ob.frame_start) begin
      b_fs_cnt++;
      if (b_fs_first == 0) b_fs_first = kb;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_hsync", 32'(oa.hsync), 1);
    check("rst_vsync", 32'(oa.vsync), 1);
    check("rst_blank", 32'(oa.blank), 1);
    check("rst_px", 32'(oa.px), 0);
    check("rst_gfx", 32'(oa.gfx_addr), 0);
    check("rst_pulses", 32'({oa.line_start, oa.frame_start}), 0);
    @(negedge pclk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Mode latch on the tiny-frame instance (288 cycles per frame).
    wait_ka(100);
    @(negedge pclk); mode_c = 2'd1;
    wait_ka(287); check("mode_hold_text", 32'(dut_c.mode_q), 0);
    wait_ka(288); check("mode_take_gfx", 32'(dut_c.mode_q), 1);
    wait_ka(400);
    @(negedge pclk); mode_c = 2'd3;
    wait_ka(575); check("mode_hold_gfx", 32'(dut_c.mode_q), 1);
    wait_ka(576); check("mode_rsvd_text", 32'(dut_c.mode_q), 0);

    // End of visible line 0 on the full-size instance.
    wait_ka(640);
    check("a_px639", 32'(oa.px), 639);
    check("a_col79", 32'(oa.char_col), 79);
    check("a_gx7", 32'(oa.glyph_x), 7);
    check("a_gfx319", 32'(oa.gfx_addr), 319);
    check("a_vis", 32'(oa.blank), 0);
    wait_ka(641);
    check("a_blank_on", 32'(oa.blank), 1);
    check("a_px_hold", 32'(oa.px), 639);
    wait_ka(1601);
    check("a_hs_first", a_hs_first, 657);
    check("a_hs_width", a_hs_cnt, 96);
    check("a_blank_line", a_bl_cnt, 160);
    check("a_ls_n", a_ls_n, 2);
    check("a_ls0", a_ls_k[0], 800);
    check("a_ls1", a_ls_k[1], 1600);

    // Blink counter on the tiny-frame instance.
    wait_ka(4607); check("c_fc15", 32'(oc.frame_cnt), 15);
    wait_ka(4608); check("c_fc16_blink", 32'(oc.frame_cnt[4]), 1);
    wait_ka(9215); check("c_fc31", 32'(oc.frame_cnt), 31);
    wait_ka(9216); check("c_fc_wrap", 32'(oc.frame_cnt), 0);

    // Bottom-right visible pixel on the full-height instance (h=15, v=479).
    wait_ka(11512);
    check("b_py479", 32'(ob.py), 479);
    check("b_row29", 32'(ob.char_row), 29);
    check("b_gy15", 32'(ob.glyph_y), 15);
    check("b_col1", 32'(ob.char_col), 1);
    check("b_gx7", 32'(ob.glyph_x), 7);
    check("b_gfx", 32'(ob.gfx_addr), 76487);
    wait_ka(12600);
    check("b_fs_edge", 32'(ob.frame_start), 1);
    check("b_fs_first", b_fs_first, 12600);
    check("b_vs_first", b_vs_first, 11761);
    check("b_vs_width", b_vs_cnt, 48);
    check("b_blank_frame", b_bl_cnt, 4920);

    // Mid-frame reset at h=10, v=200 of the second frame.
    wait_kb(17410);
    @(negedge pclk);
    rst_b = 1'b0;
    #1;
    check("b_rst_hsync", 32'(ob.hsync), 1);
    check("b_rst_blank", 32'(ob.blank), 1);
    check("b_rst_px", 32'(ob.px), 0);
    check("b_rst_py", 32'(ob.py), 0);
    check("b_rst_gfx", 32'(ob.gfx_addr), 0);
    check("b_rst_fc", 32'(ob.frame_cnt), 0);
    repeat (3) @(negedge pclk);
    rst_b = 1'b1;
    b_fs_first = 0;
    b_fs_cnt = 0;
    wait_kb(12600);
    check("b_refs_edge", 32'(ob.frame_start), 1);
    check("b_refs_first", b_fs_first, 12600);
    check("b_refs_cnt", b_fs_cnt, 1);

    @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
